// File: rtl/addr_mult_ctrl.sv
// Two-requester front end for a shared, fully pipelined multiplier: round-robin grant,
// per-register reservation scoreboard and a tag pipeline that times the A-register writeback.
module addr_mult_ctrl #(
  parameter int LATENCY = 6,
  parameter int TAG_W   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic [23:0]           req0_aj,
  input  logic [23:0]           req0_ak,
  input  logic [TAG_W-1:0]      req0_tag,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [23:0]           req1_aj,
  input  logic [23:0]           req1_ak,
  input  logic [TAG_W-1:0]      req1_tag,
  output logic                  req1_ready,
  output logic [23:0]           mul_aj,
  output logic [23:0]           mul_ak,
  input  logic [23:0]           mul_result,
  output logic                  wb_valid,
  output logic [TAG_W-1:0]      wb_tag,
  output logic                  wb_src,
  output logic [23:0]           wb_data,
  output logic [2**TAG_W-1:0]   resv,
  output logic [3:0]            inflight
);

  localparam int NREG = 2**TAG_W;

  logic [NREG-1:0]    resv_q, resv_d;
  logic [3:0]         inflight_q, inflight_d;
  logic               ptr_q, ptr_d;
  logic [LATENCY-1:0] pipe_vld_q;
  logic [LATENCY-1:0] pipe_src_q;
  logic [TAG_W-1:0]   pipe_tag_q [LATENCY];

  logic               elig0, elig1, gnt0, gnt1, any_gnt;
  logic [TAG_W-1:0]   gnt_tag;

  always_comb begin
    elig0   = req0_valid & ~resv_q[req0_tag];
    elig1   = req1_valid & ~resv_q[req1_tag];
    // ptr_q names the requester favoured when both are eligible.
    gnt0    = ~rst & elig0 & (~elig1 | ~ptr_q);
    gnt1    = ~rst & elig1 & (~elig0 | ptr_q);
    any_gnt = gnt0 | gnt1;
    gnt_tag = gnt1 ? req1_tag : req0_tag;

    req0_ready = gnt0;
    req1_ready = gnt1;
    mul_aj     = gnt0 ? req0_aj : (gnt1 ? req1_aj : '0);
    mul_ak     = gnt0 ? req0_ak : (gnt1 ? req1_ak : '0);

    wb_valid = ~rst & pipe_vld_q[LATENCY-1];
    wb_tag   = wb_valid ? pipe_tag_q[LATENCY-1] : '0;
    wb_src   = wb_valid & pipe_src_q[LATENCY-1];
    wb_data  = mul_result;

    // Clear before set: a granted tag can never equal the retiring one (it is still reserved).
    resv_d = resv_q;
    if (wb_valid) resv_d[wb_tag] = 1'b0;
    if (any_gnt)  resv_d[gnt_tag] = 1'b1;

    inflight_d = inflight_q;
    if (any_gnt && !wb_valid)      inflight_d = inflight_q + 4'd1;
    else if (!any_gnt && wb_valid) inflight_d = inflight_q - 4'd1;

    ptr_d = any_gnt ? ~gnt1 : ptr_q;

    resv     = resv_q;
    inflight = inflight_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resv_q     <= '0;
      inflight_q <= '0;
      ptr_q      <= 1'b0;
      pipe_vld_q <= '0;
      pipe_src_q <= '0;
      for (int i = 0; i < LATENCY; i++) pipe_tag_q[i] <= '0;
    end else begin
      resv_q     <= resv_d;
      inflight_q <= inflight_d;
      ptr_q      <= ptr_d;
      // Issue stage: the grant enters the tag pipeline alongside the multiplier operands.
      pipe_vld_q[0] <= any_gnt;
      pipe_src_q[0] <= gnt1;
      pipe_tag_q[0] <= any_gnt ? gnt_tag : '0;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_src_q[i] <= pipe_src_q[i-1];
        pipe_tag_q[i] <= pipe_tag_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_addr_mult_ctrl.sv
// Scoreboard bench for addr_mult_ctrl: a bench-side multiplier with LATENCY delay, a reference
// model of outstanding operations deciding grants, and a monitor matching every writeback.
module tb_addr_mult_ctrl;
  localparam int LAT = 6;
  localparam int TW  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req1_valid;
  logic [23:0]   req0_aj, req0_ak, req1_aj, req1_ak;
  logic [TW-1:0] req0_tag, req1_tag;
  logic          req0_ready, req1_ready;
  logic [23:0]   mul_aj, mul_ak;
  logic [23:0]   mul_result = '0;
  logic          wb_valid, wb_src;
  logic [TW-1:0] wb_tag;
  logic [23:0]   wb_data;
  logic [7:0]    resv;
  logic [3:0]    inflight;

  addr_mult_ctrl #(.LATENCY(LAT), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_aj(req0_aj), .req0_ak(req0_ak), .req0_tag(req0_tag),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_aj(req1_aj), .req1_ak(req1_ak), .req1_tag(req1_tag),
    .req1_ready(req1_ready),
    .mul_aj(mul_aj), .mul_ak(mul_ak), .mul_result(mul_result),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_src(wb_src), .wb_data(wb_data),
    .resv(resv), .inflight(inflight)
  );

  always #5 clk = ~clk;

  typedef struct { int due; int tag; int src; logic [23:0] data; } exp_t;
  typedef struct { int issue; int tag; } op_t;

  exp_t sb[$];
  op_t  ops[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   fav = 0;
  logic [23:0] prod_buf [16] = '{default: 24'h0};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // External multiplier: product of the operands seen in cycle c appears in cycle c+LAT.
  always @(negedge clk) prod_buf[cyc % 16] <= mul_aj * mul_ak;
  always @(posedge clk) begin
    #1;
    mul_result <= prod_buf[(cyc + 16 - LAT) % 16];
  end

  // Reference model: an operation reserves its tag during cycles issue+1 .. issue+LAT.
  always @(negedge clk) begin
    logic [7:0]  rmask;
    int          cnt, g;
    bit          e0, e1;
    logic [23:0] ea, eb;
    exp_t        e;
    while (ops.size() > 0 && cyc - ops[0].issue > LAT) void'(ops.pop_front());
    rmask = '0;
    cnt = 0;
    foreach (ops[i]) begin
      rmask[ops[i].tag] = 1'b1;
      cnt++;
    end
    if (rst) begin
      chk("rst_ready", {req0_ready, req1_ready}, 0);
      chk("rst_mul", {mul_aj, 8'h0} | {8'h0, mul_ak}, 0);
      ops.delete();
      sb.delete();
      fav = 0;
    end else begin
      chk("resv", resv, rmask);
      chk("inflight", inflight, cnt);
      e0 = req0_valid && !rmask[req0_tag];
      e1 = req1_valid && !rmask[req1_tag];
      if (e0 && e1) g = fav;
      else if (e0)  g = 0;
      else if (e1)  g = 1;
      else          g = -1;
      chk("ready0", req0_ready, g == 0);
      chk("ready1", req1_ready, g == 1);
      ea = (g == 0) ? req0_aj : (g == 1) ? req1_aj : 24'h0;
      eb = (g == 0) ? req0_ak : (g == 1) ? req1_ak : 24'h0;
      chk("mul_aj", mul_aj, ea);
      chk("mul_ak", mul_ak, eb);
      if (g >= 0) begin
        op_t o;
        o.issue = cyc;
        o.tag   = (g == 0) ? int'(req0_tag) : int'(req1_tag);
        ops.push_back(o);
        e.due  = cyc + LAT;
        e.tag  = o.tag;
        e.src  = g;
        e.data = 24'((ea * eb) % (1 << 24));
        sb.push_back(e);
        fav = 1 - g;
      end
    end
  end

  // Monitor: every writeback must match the oldest expected entry, in its own cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      chk("rst_wb_valid", wb_valid, 0);
    end else begin
      while (sb.size() > 0 && sb[0].due < cyc) begin
        total++;
        bad++;
        $display("FAIL wb_missing cyc=%0d got=none want=tag%0d due%0d", cyc, sb[0].tag, sb[0].due);
        void'(sb.pop_front());
      end
      if (wb_valid) begin
        total++;
        if (sb.size() == 0 || sb[0].due != cyc) begin
          bad++;
          $display("FAIL wb_unexpected cyc=%0d got=tag%0d want=no_writeback", cyc, wb_tag);
        end else begin
          e = sb.pop_front();
          chk("wb_tag", wb_tag, e.tag);
          chk("wb_src", wb_src, e.src);
          chk("wb_data", wb_data, e.data);
        end
      end else begin
        chk("wb_idle_tag_src", {wb_tag, wb_src}, 0);
      end
    end
  end

  task automatic drive(input bit r, input bit v0, input int t0, input logic [23:0] a0, b0,
                       input bit v1, input int t1, input logic [23:0] a1, b1);
    rst = r;
    req0_valid = v0; req0_tag = TW'(t0); req0_aj = a0; req0_ak = b0;
    req1_valid = v1; req1_tag = TW'(t1); req1_aj = a1; req1_ak = b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 0; req0_tag = 0; req0_aj = 0; req0_ak = 0;
    req1_valid = 0; req1_tag = 0; req1_aj = 0; req1_ak = 0;
    @(posedge clk);
    #1;
    // Reset held with requests pending: nothing may be granted.
    drive(1, 1, 1, 24'd7, 24'd9, 1, 2, 24'd4, 24'd4);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    // Single issue 3*5 to tag 2.
    drive(0, 1, 2, 24'd3, 24'd5, 0, 0, 0, 0);
    idle(8);
    // Round robin: tags 1 and 4 together, req1 held one more cycle.
    drive(0, 1, 1, 24'd11, 24'd13, 1, 4, 24'd17, 24'd19);
    drive(0, 0, 0, 0, 0, 1, 4, 24'd17, 24'd19);
    idle(9);
    // Hazard: tag 3 in flight, req1 retries tag 3.
    drive(0, 1, 3, 24'd6, 24'd7, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 0, 0, 1, 3, 24'd100, 24'd200);
    idle(8);
    // Same tag on both requesters in one cycle.
    drive(0, 1, 6, 24'd2, 24'd2, 1, 6, 24'd3, 24'd3);
    idle(8);
    // Throughput: six back-to-back grants.
    for (int t = 0; t < 6; t++) drive(0, 1, t, 24'($urandom), 24'($urandom), 0, 0, 0, 0);
    idle(8);
    // Product wraps to zero.
    drive(0, 1, 5, 24'h800000, 24'd2, 0, 0, 0, 0);
    idle(7);
    // Reset mid-flight discards three operations.
    for (int t = 0; t < 3; t++) drive(0, 1, t, 24'd5 + 24'(t), 24'd9, 0, 0, 0, 0);
    idle(2);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(12);
    // Random traffic with occasional reset.
    for (int i = 0; i < 500; i++) begin
      drive($urandom_range(0, 99) == 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 7), 24'($urandom), 24'($urandom),
            $urandom_range(0, 3) != 0, $urandom_range(0, 7), 24'($urandom), 24'($urandom));
    end
    idle(LAT + 4);
    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
